// File: rtl/secure_reg_arb.sv
// Two-requester register block: one CFG register {lock, we, re} that gates
// access to the DATA registers. Requesters are served one at a time, round-robin.
module secure_reg_arb #(
  parameter int unsigned DW   = 8,
  parameter int unsigned NREG = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_valid,
  input  logic [1:0]                   req_write,
  input  logic [2*$clog2(NREG)-1:0]    req_addr,
  input  logic [2*DW-1:0]              req_wdata,
  output logic [1:0]                   req_ready,
  output logic [1:0]                   rsp_valid,
  input  logic [1:0]                   rsp_ready,
  output logic [DW-1:0]                rsp_rdata,
  output logic                         rsp_err,
  output logic [2:0]                   cfg_q
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic            rr_q;
  logic            gnt_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   data_q [NREG];
  logic [DW-1:0]   rdata_q;
  logic            err_q;

  logic            any_valid;
  logic            gnt_idx;
  logic            rsp_hs;
  logic            addr_ok;
  logic            is_cfg;
  logic            cfg_wr;
  logic            data_wr;
  logic            acc_err;
  logic [DW-1:0]   acc_rdata;

  assign any_valid = |req_valid;
  // rr only breaks ties; a lone requester always wins
  assign gnt_idx   = (req_valid == 2'b11) ? rr_q : req_valid[1];
  assign rsp_hs    = (state_q == StResp) && rsp_ready[gnt_q];
  assign addr_ok   = 32'(addr_q) < NREG;
  assign is_cfg    = (addr_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   if (rsp_hs) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Access decode uses the CFG value from before this transaction
  always_comb begin
    acc_err   = 1'b0;
    acc_rdata = '0;
    cfg_wr    = 1'b0;
    data_wr   = 1'b0;
    if (!addr_ok) begin
      acc_err = 1'b1;
    end else if (is_cfg) begin
      if (write_q) begin
        if (cfg_q[2]) acc_err = 1'b1;
        else          cfg_wr  = 1'b1;
      end else begin
        acc_rdata = DW'(cfg_q);
      end
    end else if (write_q) begin
      if (cfg_q[1]) data_wr = 1'b1;
      else          acc_err = 1'b1;
    end else begin
      if (cfg_q[0]) acc_rdata = data_q[addr_q];
      else          acc_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= 1'b0;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      cfg_q   <= 3'b000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(NREG); i++) data_q[i] <= '0;
    end else begin
      if (state_q == StIdle && any_valid) begin
        gnt_q   <= gnt_idx;
        addr_q  <= gnt_idx ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
        write_q <= req_write[gnt_idx];
        wdata_q <= gnt_idx ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
      end
      if (state_q == StAccess) begin
        rdata_q <= acc_rdata;
        err_q   <= acc_err;
        if (cfg_wr)  cfg_q          <= wdata_q[2:0];
        if (data_wr) data_q[addr_q] <= wdata_q;
      end
      if (rsp_hs) rr_q <= ~gnt_q;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: if (any_valid) req_ready[gnt_idx] = 1'b1;
        StResp: begin
          rsp_valid[gnt_q] = 1'b1;
          rsp_rdata        = rdata_q;
          rsp_err          = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_secure_reg_arb.sv
// Directed plus randomized bench for secure_reg_arb, checked against a
// transaction-level model of the register rules and round-robin arbitration.
module tb_secure_reg_arb;
  localparam int DW   = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [2:0]      cfg_q;

  int total = 0;
  int bad   = 0;

  logic [2:0]    m_cfg;
  logic [DW-1:0] m_reg [NREG];
  int            m_rr;

  secure_reg_arb #(.DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cfg_q(cfg_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cfg = 3'b000;
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_rr = 0;
  endtask

  task automatic model_op(input bit wr, input int addr, input logic [DW-1:0] wd,
                          output logic [DW-1:0] rd, output bit er);
    rd = '0;
    er = 1'b0;
    if (addr >= NREG) er = 1'b1;
    else if (addr == 0) begin
      if (!wr) rd = {5'b0, m_cfg};
      else if (m_cfg[2]) er = 1'b1;
      else m_cfg = wd[2:0];
    end else if (wr) begin
      if (m_cfg[1]) m_reg[addr] = wd;
      else er = 1'b1;
    end else begin
      if (m_cfg[0]) rd = m_reg[addr];
      else er = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one transaction starting in IDLE; returns 1 ns after the edge back into IDLE.
  task automatic txn(input logic [1:0] mask, input logic [1:0] wr, input logic [2*AW-1:0] addr,
                     input logic [2*DW-1:0] wd, input int hold, output logic [1:0] rdy);
    logic [DW-1:0] erd;
    bit            eer;
    int            win;
    int            waited;
    req_valid = mask;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    rsp_ready = 2'b00;
    win = (mask == 2'b11) ? m_rr : (mask[1] ? 1 : 0);
    #1;
    waited = 0;
    while (req_ready == 2'b00 && waited < 4) begin
      @(posedge clk); #2;
      waited++;
    end
    rdy = req_ready;
    check("grant_wait", 32'(waited), 32'(0));
    check("req_ready", 32'(req_ready), 32'(2'b01 << win));
    model_op(wr[win], int'(addr[win*AW +: AW]), wd[win*DW +: DW], erd, eer);
    @(posedge clk); #1;
    req_valid[win] = 1'b0;
    #1;
    check("access_rsp_valid", 32'(rsp_valid), 32'(0));
    check("access_req_ready", 32'(req_ready), 32'(0));
    @(posedge clk); #2;
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", 32'(rsp_valid), 32'(2'b01 << win));
      check("hold_rdata", 32'(rsp_rdata), 32'(erd));
      check("hold_err", 32'(rsp_err), 32'(eer));
      check("hold_req_ready", 32'(req_ready), 32'(0));
      @(posedge clk); #2;
    end
    rsp_ready[win] = 1'b1;
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(2'b01 << win));
    check("rsp_rdata", 32'(rsp_rdata), 32'(erd));
    check("rsp_err", 32'(rsp_err), 32'(eer));
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    m_rr = 1 - win;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("rst_req_ready", 32'(req_ready), 32'(0));
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    end else if (rst === 1'b0) begin
      check("one_ready", 32'(req_ready == 2'b11), 32'(0));
      if (rsp_valid == 2'b00) check("idle_rsp_zero", {23'b0, rsp_rdata, rsp_err}, 32'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rdy;
    rst = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_cfg", 32'(cfg_q), 32'(0));
    check("reset_req_ready", 32'(req_ready), 32'(0));
    check("reset_rsp", {22'b0, rsp_valid, rsp_rdata}, 32'(0));
    rst = 1'b0;
    req_valid = 2'b00;
    model_reset();

    // read with re=0 is refused
    txn(2'b01, 2'b00, {2'd0, 2'd1}, 16'h0, 0, rdy);
    // enable, write, read back from the other requester
    txn(2'b01, 2'b01, {2'd0, 2'd0}, {8'h00, 8'h03}, 0, rdy);
    check("cfg_011", 32'(cfg_q), 32'(3'b011));
    txn(2'b01, 2'b01, {2'd0, 2'd2}, {8'h00, 8'hA5}, 0, rdy);
    txn(2'b10, 2'b00, {2'd2, 2'd0}, 16'h0, 0, rdy);

    // r1 holds off its response for five cycles while r0 keeps requesting
    txn(2'b11, 2'b00, {2'd2, 2'd1}, 16'h0, 0, rdy);
    check("hold_pre_grant", 32'(rdy), 32'(2'b01));
    txn(2'b11, 2'b00, {2'd2, 2'd1}, 16'h0, 5, rdy);
    check("hold_grant", 32'(rdy), 32'(2'b10));

    // lock
    txn(2'b01, 2'b01, {2'd0, 2'd0}, {8'h00, 8'h07}, 0, rdy);
    txn(2'b01, 2'b01, {2'd0, 2'd0}, {8'h00, 8'h00}, 0, rdy);
    check("locked_cfg", 32'(cfg_q), 32'(3'b111));
    txn(2'b01, 2'b01, {2'd0, 2'd3}, {8'h00, 8'h5A}, 0, rdy);
    txn(2'b10, 2'b00, {2'd3, 2'd0}, 16'h0, 0, rdy);

    // round-robin from reset with both requesters always valid
    do_reset();
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 2'b00, {2'd1, 2'd1}, 16'h0, 0, rdy);
      check("rr_seq", 32'(rdy), (i % 2 == 1) ? 32'(2'b10) : 32'(2'b01));
    end

    // reset during the ACCESS cycle of a DATA write
    txn(2'b01, 2'b01, {2'd0, 2'd0}, {8'h00, 8'h03}, 0, rdy);
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {2'd0, 2'd3};
    req_wdata = {8'h00, 8'h3C};
    #1;
    check("abort_grant", 32'(req_ready), 32'(2'b01));
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    #1;
    check("abort_cfg", 32'(cfg_q), 32'(0));
    @(posedge clk); #1;
    check("abort_no_rsp", 32'(rsp_valid), 32'(0));
    txn(2'b01, 2'b01, {2'd0, 2'd0}, {8'h00, 8'h03}, 0, rdy);
    txn(2'b01, 2'b00, {2'd0, 2'd3}, 16'h0, 0, rdy);

    for (int n = 0; n < 60; n++) begin
      logic [1:0]  mask, wr;
      logic [3:0]  ad;
      logic [15:0] wd;
      int          hold;
      if ($urandom_range(0, 14) == 0) do_reset();
      mask = 2'($urandom_range(1, 3));
      wr   = 2'($urandom);
      ad   = 4'($urandom);
      wd   = 16'($urandom);
      // keep lock rare so DATA traffic stays interesting
      if ($urandom_range(0, 7) != 0) begin
        wd[2]  = 1'b0;
        wd[10] = 1'b0;
      end
      hold = $urandom_range(0, 2);
      txn(mask, wr, ad, wd, hold, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/secure_reg_arb.md
SECURE_REG_ARB -- requirements
Module: secure_reg_arb

Interface
REQ-001 The block SHALL have parameter DW, default 8, data width of each register and of the write/read data.
REQ-002 The block SHALL have parameter NREG, default 4, number of registers. Index 0 is CFG; indices 1..NREG-1 are DATA.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 2, per-requester request valid.
REQ-006 The block SHALL have port req_write, input, 2, per-requester operation: 1 = write, 0 = read.
REQ-007 The block SHALL have port req_addr, input, 2*clog2(NREG), packed per-requester register index; requester r uses slice r.
REQ-008 The block SHALL have port req_wdata, input, 2*DW, packed per-requester write data.
REQ-009 The block SHALL have port req_ready, output, 2, per-requester accept strobe.
REQ-010 The block SHALL have port rsp_valid, output, 2, per-requester response valid.
REQ-011 The block SHALL have port rsp_ready, input, 2, per-requester response accept.
REQ-012 The block SHALL have port rsp_rdata, output, DW, shared read data; qualified by rsp_valid.
REQ-013 The block SHALL have port rsp_err, output, 1, shared error flag; qualified by rsp_valid.
REQ-014 The block SHALL have port cfg_q, output, 3, current CFG bits {lock, we, re}.

Function
REQ-015 CFG SHALL hold three bits: bit0 = re (DATA reads enabled), bit1 = we (DATA writes enabled), bit2 = lock.
REQ-016 The block SHALL run FSM IDLE -> ACCESS -> RESP -> IDLE, with one transaction in flight at a time.
REQ-017 In IDLE with any req_valid=1, the block SHALL grant one requester and pulse its req_ready for that cycle only, latch addr/write/wdata, and move to ACCESS. With no request, it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: pointer rr starts at 0 after reset. If both requesters are valid, the one selected by rr SHALL win. If only one is valid, it SHALL win regardless of rr.
REQ-019 rr SHALL be set to (granted index + 1) mod 2 when the response handshake completes.
REQ-020 In ACCESS, the block SHALL perform the operation and register the response data and error, then move to RESP.
REQ-021 CFG write SHALL update bits [2:0] from wdata[2:0] only if lock=0; otherwise CFG is unchanged and err=1.
REQ-022 Once lock=1, it SHALL remain 1 until rst.
REQ-023 CFG read SHALL always succeed, returning {DW-3 zeros, lock, we, re}, with err=0.
REQ-024 DATA write SHALL update the register only if we=1; otherwise the register is unchanged and err=1.
REQ-025 DATA read SHALL return register contents only if re=1; otherwise rdata=0 and err=1.
REQ-026 Any write response SHALL have rdata=0.
REQ-027 An address >= NREG (non-power-of-2 NREG) SHALL have no effect and SHALL respond with err=1 and rdata=0.
REQ-028 In RESP, rsp_valid SHALL be asserted only for the granted requester. rsp_rdata and rsp_err SHALL be held stable until rsp_ready of that requester is 1, after which the block returns to IDLE on the next cycle.
REQ-029 Latency SHALL be: req_ready at cycle T gives rsp_valid at T+2 at the earliest. Maximum throughput SHALL be one transaction per 3 cycles.
REQ-030 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.
REQ-031 Requests arriving outside IDLE SHALL NOT receive req_ready; requesters hold req_valid until accepted.
REQ-032 A CFG write changing we/re SHALL take effect for the next transaction, never for the one that writes it.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL go to state IDLE, set rr=0, set CFG=3'b000, set all DATA registers to 0, and drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, cfg_q=0.
REQ-034 rst asserted during ACCESS or RESP SHALL abandon the transaction with no register update and no response.
REQ-035 rst SHALL have priority over every other input in the same cycle.

Verification
REQ-036 Reset, then r0 reads addr 1 -> rsp_valid[0] at T+2, rdata=0, err=1 (re=0).
REQ-037 r0 writes CFG=3'b011, then r0 writes addr 2 = 8'hA5, then r1 reads addr 2 -> third response rdata=8'hA5, err=0.
REQ-038 Write CFG=3'b111, then write CFG=3'b000 -> second response err=1; cfg_q stays 3'b111; a DATA write still succeeds.
REQ-039 Both requesters continuously valid for 4 transactions after reset -> grants r0, r1, r0, r1; never two req_ready in one cycle.
REQ-040 Hold rsp_ready[1]=0 for 5 cycles during r1's response -> rsp_valid[1], rdata, and err stay stable; no new req_ready issued until the handshake completes.
REQ-041 Assert rst in the ACCESS cycle of a DATA write of 8'h3C -> no response; register reads back 0 after CFG is re-enabled.
